// File: rtl/if_stage.sv
// Instruction-fetch stage: program counter plus the IF/ID pipeline register.
// Branch redirect beats stall; flush or branch turns the IF/ID entry into a bubble.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic [31:0] Instruction_i,
  output logic [31:0] PC_o,
  output logic [31:0] IF_ID_PC_o,
  output logic [31:0] IF_ID_PCPlus4_o,
  output logic [31:0] IF_ID_Instruction_o,
  output logic        IF_ID_valid_o,
  output logic        misalign_o
);

  logic [31:0] pc_reg, pc_next;
  logic [31:0] id_pc_reg, id_pc_next;
  logic [31:0] id_pc4_reg, id_pc4_next;
  logic [31:0] id_instr_reg, id_instr_next;
  logic        id_valid_reg, id_valid_next;
  logic        misalign_reg, misalign_next;
  logic [31:0] pc_plus4;
  logic        make_bubble;

  assign pc_plus4 = pc_reg + 32'd4;

  always_comb begin
    pc_next       = pc_reg;
    id_pc_next    = id_pc_reg;
    id_pc4_next   = id_pc4_reg;
    id_instr_next = id_instr_reg;
    id_valid_next = id_valid_reg;
    misalign_next = 1'b0;
    make_bubble   = 1'b0;

    if (branch_taken_i) begin
      // Target is forced to word alignment; the dropped low bits raise a one-cycle flag.
      pc_next       = {branch_target_i[31:2], 2'b00};
      misalign_next = |branch_target_i[1:0];
      make_bubble   = 1'b1;
    end else if (stall_i) begin
      make_bubble = flush_i;
    end else begin
      pc_next = pc_plus4;
      if (flush_i) begin
        make_bubble = 1'b1;
      end else begin
        id_pc_next    = pc_reg;
        id_pc4_next   = pc_plus4;
        id_instr_next = Instruction_i;
        id_valid_next = 1'b1;
      end
    end

    if (make_bubble) begin
      id_pc_next    = 32'd0;
      id_pc4_next   = 32'd0;
      id_instr_next = NOP_INSTR;
      id_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_reg       <= RESET_PC;
      id_pc_reg    <= 32'd0;
      id_pc4_reg   <= 32'd0;
      id_instr_reg <= NOP_INSTR;
      id_valid_reg <= 1'b0;
      misalign_reg <= 1'b0;
    end else begin
      pc_reg       <= pc_next;
      id_pc_reg    <= id_pc_next;
      id_pc4_reg   <= id_pc4_next;
      id_instr_reg <= id_instr_next;
      id_valid_reg <= id_valid_next;
      misalign_reg <= misalign_next;
    end
  end

  assign PC_o                = pc_reg;
  assign IF_ID_PC_o          = id_pc_reg;
  assign IF_ID_PCPlus4_o     = id_pc4_reg;
  assign IF_ID_Instruction_o = id_instr_reg;
  assign IF_ID_valid_o       = id_valid_reg;
  assign misalign_o          = misalign_reg;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a small combinational instruction memory model,
// one step per clock, every output compared against hand-computed values.
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic [31:0] id_instr;
  logic        id_valid;
  logic        misalign;

  int checks = 0;
  int errors = 0;

  if_stage dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .stall_i             (stall),
    .flush_i             (flush),
    .branch_taken_i      (branch_taken),
    .branch_target_i     (branch_target),
    .Instruction_i       (instr),
    .PC_o                (pc),
    .IF_ID_PC_o          (id_pc),
    .IF_ID_PCPlus4_o     (id_pc4),
    .IF_ID_Instruction_o (id_instr),
    .IF_ID_valid_o       (id_valid),
    .misalign_o          (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Three real instructions at 0/4/8; every other word is address ^ A5A50000.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   mem_word = 32'h0050_0093;
      32'h4:   mem_word = 32'h00A0_0113;
      32'h8:   mem_word = 32'h0020_81B3;
      default: mem_word = a ^ 32'hA5A5_0000;
    endcase
  endfunction

  assign instr = mem_word(pc);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_idpc,
                           input logic [31:0] e_pc4, input logic [31:0] e_instr,
                           input logic e_valid, input logic e_mis);
    check({tag, ".pc"},       pc,               e_pc);
    check({tag, ".id_pc"},    id_pc,            e_idpc);
    check({tag, ".id_pc4"},   id_pc4,           e_pc4);
    check({tag, ".id_instr"}, id_instr,         e_instr);
    check({tag, ".valid"},    {31'd0, id_valid}, {31'd0, e_valid});
    check({tag, ".misalign"}, {31'd0, misalign}, {31'd0, e_mis});
    $display("step %-14s pc=%h id_pc=%h id_pc4=%h id_instr=%h valid=%0b mis=%0b",
             tag, pc, id_pc, id_pc4, id_instr, id_valid, misalign);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
    step();
    check_all("reset", 32'h0, 32'h0, 32'h0, 32'h13, 1'b0, 1'b0);

    rst = 1'b0;
    step();
    check_all("run0", 32'h4, 32'h0, 32'h4, 32'h0050_0093, 1'b1, 1'b0);
    step();
    check_all("run1", 32'h8, 32'h4, 32'h8, 32'h00A0_0113, 1'b1, 1'b0);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_all($sformatf("stall%0d", i), 32'h8, 32'h4, 32'h8, 32'h00A0_0113, 1'b1, 1'b0);
    end
    stall = 1'b0;
    step();
    check_all("release", 32'hC, 32'h8, 32'hC, 32'h0020_81B3, 1'b1, 1'b0);

    // Branch wins over a simultaneous stall.
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h40;
    step();
    check_all("br_stall", 32'h40, 32'h0, 32'h0, 32'h13, 1'b0, 1'b0);
    stall = 1'b0; branch_taken = 1'b0;
    step();
    check_all("after_br", 32'h44, 32'h40, 32'h44, 32'hA5A5_0040, 1'b1, 1'b0);

    branch_taken = 1'b1; branch_target = 32'h46;
    step();
    check_all("br_misal", 32'h44, 32'h0, 32'h0, 32'h13, 1'b0, 1'b1);
    branch_taken = 1'b0;
    step();
    check_all("misal_clr", 32'h48, 32'h44, 32'h48, 32'hA5A5_0044, 1'b1, 1'b0);

    branch_taken = 1'b1; branch_target = 32'hC;
    step();
    check_all("br_c", 32'hC, 32'h0, 32'h0, 32'h13, 1'b0, 1'b0);
    branch_taken = 1'b0;
    step();
    check_all("to_10", 32'h10, 32'hC, 32'h10, 32'hA5A5_000C, 1'b1, 1'b0);
    flush = 1'b1;
    step();
    check_all("flush", 32'h14, 32'h0, 32'h0, 32'h13, 1'b0, 1'b0);
    flush = 1'b0;

    branch_taken = 1'b1; branch_target = 32'hC;
    step();
    branch_taken = 1'b0;
    step();
    check_all("to_10b", 32'h10, 32'hC, 32'h10, 32'hA5A5_000C, 1'b1, 1'b0);
    stall = 1'b1; flush = 1'b1;
    step();
    check_all("stall_flush", 32'h10, 32'h0, 32'h0, 32'h13, 1'b0, 1'b0);
    stall = 1'b0; flush = 1'b0;
    step();
    check_all("resume", 32'h14, 32'h10, 32'h14, 32'hA5A5_0010, 1'b1, 1'b0);

    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    step();
    check_all("br_top", 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h13, 1'b0, 1'b0);
    branch_taken = 1'b0;
    step();
    check_all("wrap", 32'h0, 32'hFFFF_FFFC, 32'h0, 32'h5A5A_FFFC, 1'b1, 1'b0);

    // Reset overrides branch, stall and flush arriving in the same cycle.
    rst = 1'b1; branch_taken = 1'b1; branch_target = 32'h83; stall = 1'b1; flush = 1'b1;
    step();
    check_all("rst_mid", 32'h0, 32'h0, 32'h0, 32'h13, 1'b0, 1'b0);
    rst = 1'b0; branch_taken = 1'b0; stall = 1'b0; flush = 1'b0;
    step();
    check_all("post_rst", 32'h4, 32'h0, 32'h4, 32'h0050_0093, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage: owns the program counter and the IF/ID pipeline register.
- Drives PC_o into InstructionMem PC_i and takes the combinational Instruction_o back on Instruction_i in the same cycle.
- Registers PC, PC+4 and the instruction for the decode stage.
- Supports stall from hazard detection, and flush plus PC redirect from branch/jump resolution.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- NOP_INSTR, 32'h00000013, bubble instruction (addi x0,x0,0) inserted on flush/reset.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- stall_i  input  1  hold PC and IF/ID register.
- flush_i  input  1  replace IF/ID contents with bubble.
- branch_taken_i  input  1  redirect PC to branch_target_i.
- branch_target_i  input  32  redirect address.
- Instruction_i  input  32  instruction word from InstructionMem (combinational from PC_o).
- PC_o  output  32  current fetch PC, to InstructionMem PC_i.
- IF_ID_PC_o  output  32  PC of the registered instruction.
- IF_ID_PCPlus4_o  output  32  IF_ID_PC_o + 4.
- IF_ID_Instruction_o  output  32  registered instruction.
- IF_ID_valid_o  output  1  registered instruction is real (not a bubble).
- misalign_o  output  1  registered flag: last redirect target was not word-aligned.

Behaviour:
- All state updates on rising clk_i. Priority: rst_i > branch_taken_i > stall_i > normal.
- Reset values:
  - PC_o = RESET_PC
  - IF_ID_PC_o = 0
  - IF_ID_PCPlus4_o = 0
  - IF_ID_Instruction_o = NOP_INSTR
  - IF_ID_valid_o = 0
  - misalign_o = 0
- Reset asserted mid-operation overrides any stall, flush or branch in that cycle.
- Normal (no stall, flush or branch):
  - PC <= PC + 4, modulo 2^32; 32'hFFFFFFFC wraps to 0.
  - IF/ID <= {PC_o, PC_o+4, Instruction_i}, valid <= 1.
- Fetch-to-decode latency: 1 cycle. The instruction at PC_o appears on IF_ID_Instruction_o after the next edge.
- branch_taken_i = 1:
  - PC <= {branch_target_i[31:2], 2'b00}.
  - IF/ID <= bubble (instruction NOP_INSTR, valid 0, PC fields 0), regardless of stall_i or flush_i.
  - misalign_o <= (branch_target_i[1:0] != 0).
- misalign_o is cleared on the next edge without a branch; it is a one-cycle pulse per offending redirect.
- stall_i = 1 (no branch):
  - PC holds.
  - IF/ID holds, unless flush_i = 1, in which case IF/ID <= bubble and PC still holds.
- flush_i = 1, stall_i = 0 (no branch): PC <= PC + 4; IF/ID <= bubble.
- Bubble definition: IF_ID_Instruction_o = NOP_INSTR, IF_ID_valid_o = 0, IF_ID_PC_o = 0, IF_ID_PCPlus4_o = 0.
- IF_ID_PCPlus4_o is always the registered PC + 4, except for bubbles.
- PC_o is a register output with no combinational path from any input.
- Instruction_i is sampled only at the clock edge.
- Multi-cycle stall: all outputs remain constant for the full duration. The first edge after stall_i drops resumes normal flow from the held PC.

Test Plan:
- Reset then free-run, with the memory holding 0x00500093, 0x00A00113, 0x002081B3 at 0x0, 0x4, 0x8:
  - PC_o steps 0 -> 4 -> 8 -> C.
  - IF_ID_Instruction_o follows one cycle later: 00500093, 00A00113, 002081B3.
  - valid goes 0 then 1; IF_ID_PCPlus4_o = 4, 8, C.
- Stall 3 cycles at PC_o = 8:
  - PC_o stays 8.
  - IF_ID_Instruction_o stays 00A00113 with IF_ID_PC_o = 4.
  - After release, PC_o = C on the next edge.
- branch_taken_i with branch_target_i = 0x40 while stall_i = 1:
  - Next edge: PC_o = 0x40, IF_ID_Instruction_o = 00000013, valid = 0, misalign_o = 0.
- branch_target_i = 0x46:
  - PC_o = 0x44, misalign_o = 1 for exactly one cycle.
- flush_i with stall_i = 0 at PC_o = 0x10:
  - PC_o = 0x14, IF/ID becomes a bubble.
  - flush_i with stall_i = 1 instead: PC_o holds 0x10, IF/ID becomes a bubble.
- Wrap and mid-run reset:
  - Redirect to 0xFFFFFFFC, then one normal cycle: PC_o = 0x00000000.
  - Assert rst_i together with branch_taken_i: PC_o = RESET_PC and all outputs at their reset values.
